// File: rtl/axi_bfm_pkg.sv
// Shared AXI definitions for the burst writer.
// Contents: the writer FSM state enum, the AXI burst-type and response
// constants, and a helper that turns a byte count into an AXI AxSIZE code.
package axi_bfm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    RESP = 3'd4
  } burst_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AxSIZE encoding is log2 of the bytes per beat.
  function automatic logic [2:0] axi_size_code(input int bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/axis_burst_buf.sv
// Burst staging buffer: a DEPTH-entry FIFO that holds the beats of one burst
// between the stream side and the AXI W channel.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears pointers/count)
//   wr_en, wr_data  push one beat
//   rd_en           pop the beat currently shown on rd_data
//   rd_data         oldest stored beat
//   count           number of beats currently stored (0..DEPTH)
module axis_burst_buf #(
  parameter int DSIZE = 32,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rd_data,
  output logic [CW-1:0]    count
);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/axis_burst_writer.sv
// AXI-Stream to AXI4 write-burst engine. Collects up to BURST_LEN stream beats
// into a buffer, then issues one INCR burst (AW, then W, then waits for B) at
// a running address that starts at cfg_base_addr for each frame.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for the first beat of a frame; latches base address
// FILL  | accepting stream beats into the buffer
// ADDR  | presenting the AW request
// DATA  | streaming buffered beats on W
// RESP  | waiting for the B response, then advance address
//
// Ports: axi_aclk/axi_reset clock and async active-high reset;
// cfg_base_addr frame start address; s_* AXI-Stream slave;
// axi_aw*/axi_w*/axi_b* AXI4 write master channels;
// frame_done one-cycle pulse after the last B of a frame;
// wr_err sticky error on a non-OKAY (or wrong-ID) write response.
module axis_burst_writer
  import axi_bfm_pkg::*;
#(
  parameter int IDSIZE    = 4,
  parameter int ASIZE     = 32,
  parameter int LSIZE     = 8,
  parameter int DSIZE     = 32,
  parameter int BURST_LEN = 16,
  parameter int AXI_ID    = 0
) (
  input  logic               axi_aclk,
  input  logic               axi_reset,
  input  logic [ASIZE-1:0]   cfg_base_addr,
  input  logic [DSIZE-1:0]   s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               s_tlast,
  output logic [IDSIZE-1:0]  axi_awid,
  output logic [ASIZE-1:0]   axi_awaddr,
  output logic [LSIZE-1:0]   axi_awlen,
  output logic [2:0]         axi_awsize,
  output logic [1:0]         axi_awburst,
  output logic               axi_awlock,
  output logic [3:0]         axi_awcache,
  output logic [2:0]         axi_awprot,
  output logic [3:0]         axi_awqos,
  output logic               axi_awvalid,
  input  logic               axi_awready,
  output logic [DSIZE-1:0]   axi_wdata,
  output logic [DSIZE/8-1:0] axi_wstrb,
  output logic               axi_wlast,
  output logic               axi_wvalid,
  input  logic               axi_wready,
  input  logic [IDSIZE-1:0]  axi_bid,
  input  logic [1:0]         axi_bresp,
  input  logic               axi_bvalid,
  output logic               axi_bready,
  output logic               frame_done,
  output logic               wr_err
);

  localparam int BYTES = DSIZE / 8;
  localparam int CW    = $clog2(BURST_LEN) + 1;

  burst_state_t   state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  widx_q, widx_d;
  logic [ASIZE-1:0] cur_addr_q, cur_addr_d;
  logic           last_frame_q, last_frame_d;

  logic s_tready_q, s_tready_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic wlast_q, wlast_d;
  logic bready_q, bready_d;
  logic frame_done_q, frame_done_d;
  logic wr_err_q, wr_err_d;

  logic [CW-1:0] buf_count;
  logic s_beat, aw_hs, w_beat, b_hs, b_bad;

  assign s_beat = s_tvalid & s_tready_q;
  assign aw_hs  = awvalid_q & axi_awready;
  assign w_beat = wvalid_q & axi_wready;
  assign b_hs   = bready_q & axi_bvalid;
  // Only one burst is ever outstanding, so any other ID is a slave fault.
  assign b_bad  = (axi_bresp != AXI_RESP_OKAY) || (axi_bid != IDSIZE'(AXI_ID));

  axis_burst_buf #(
    .DSIZE (DSIZE),
    .DEPTH (BURST_LEN)
  ) u_buf (
    .clk     (axi_aclk),
    .rst     (axi_reset),
    .wr_en   (s_beat),
    .wr_data (s_tdata),
    .rd_en   (w_beat),
    .rd_data (axi_wdata),
    .count   (buf_count)
  );

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      widx_q       <= '0;
      cur_addr_q   <= '0;
      last_frame_q <= 1'b0;
      s_tready_q   <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      frame_done_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      widx_q       <= widx_d;
      cur_addr_q   <= cur_addr_d;
      last_frame_q <= last_frame_d;
      s_tready_q   <= s_tready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      wlast_q      <= wlast_d;
      bready_q     <= bready_d;
      frame_done_q <= frame_done_d;
      wr_err_q     <= wr_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    widx_d       = widx_q;
    cur_addr_d   = cur_addr_q;
    last_frame_d = last_frame_q;
    unique case (state_q)
      IDLE: begin
        if (s_tvalid) begin
          cur_addr_d   = cfg_base_addr;
          cnt_d        = '0;
          last_frame_d = 1'b0;
          state_d      = FILL;
        end
      end
      FILL: begin
        if (s_beat) begin
          cnt_d = cnt_q + CW'(1);
          // The buffer is empty on entry to FILL, so its count tracks cnt.
          if (s_tlast || (buf_count == CW'(BURST_LEN - 1))) begin
            last_frame_d = s_tlast;
            state_d      = ADDR;
          end
        end
      end
      ADDR: begin
        if (aw_hs) begin
          widx_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_beat) begin
          if (widx_q == cnt_q - CW'(1)) state_d = RESP;
          else                          widx_d  = widx_q + CW'(1);
        end
      end
      RESP: begin
        if (b_hs) begin
          cur_addr_d = cur_addr_q + (ASIZE'(cnt_q) << $clog2(BYTES));
          cnt_d      = '0;
          state_d    = last_frame_q ? IDLE : FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered,
  // one cycle after the transition that causes them.
  always_comb begin
    s_tready_d   = (state_d == FILL);
    awvalid_d    = (state_d == ADDR);
    wvalid_d     = (state_d == DATA);
    wlast_d      = (state_d == DATA) && (widx_d == cnt_d - CW'(1));
    bready_d     = (state_d == RESP);
    frame_done_d = (state_q == RESP) && b_hs && last_frame_q;
    wr_err_d     = wr_err_q | (b_hs & b_bad);
  end

  assign s_tready    = s_tready_q;
  assign axi_awid    = IDSIZE'(AXI_ID);
  assign axi_awaddr  = cur_addr_q;
  assign axi_awlen   = LSIZE'(cnt_q - CW'(1));
  assign axi_awsize  = axi_size_code(BYTES);
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_awlock  = 1'b0;
  assign axi_awcache = 4'd0;
  assign axi_awprot  = 3'd0;
  assign axi_awqos   = 4'd0;
  assign axi_awvalid = awvalid_q;
  assign axi_wstrb   = '1;
  assign axi_wlast   = wlast_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;
  assign frame_done  = frame_done_q;
  assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_axis_burst_writer.sv
module tb_axis_burst_writer;

  localparam int IDSIZE = 4, ASIZE = 32, LSIZE = 8, DSIZE = 32, BURST_LEN = 16, AXI_ID = 0;

  logic              axi_aclk = 1'b0;
  logic              axi_reset = 1'b1;
  logic [ASIZE-1:0]  cfg_base_addr = '0;
  logic [DSIZE-1:0]  s_tdata = '0;
  logic              s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [IDSIZE-1:0] axi_awid;
  logic [ASIZE-1:0]  axi_awaddr;
  logic [LSIZE-1:0]  axi_awlen;
  logic [2:0]        axi_awsize;
  logic [1:0]        axi_awburst;
  logic              axi_awlock;
  logic [3:0]        axi_awcache;
  logic [2:0]        axi_awprot;
  logic [3:0]        axi_awqos;
  logic              axi_awvalid, axi_awready = 1'b1;
  logic [DSIZE-1:0]  axi_wdata;
  logic [3:0]        axi_wstrb;
  logic              axi_wlast, axi_wvalid, axi_wready = 1'b1;
  logic [IDSIZE-1:0] axi_bid = IDSIZE'(AXI_ID);
  logic [1:0]        axi_bresp = 2'b00;
  logic              axi_bvalid = 1'b0, axi_bready;
  logic              frame_done, wr_err;

  axis_burst_writer dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset), .cfg_base_addr(cfg_base_addr),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
    .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .frame_done(frame_done), .wr_err(wr_err)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [31:0] data; logic last; } w_t;

  aw_t exp_aw[$], obs_aw[$];
  w_t  exp_w[$],  obs_w[$];

  int total = 0, bad = 0;
  int stall = 0, err_at = -1, bcount = 0;
  int b_owed = 0, aw_out = 0, fd_cnt = 0, stab_err = 0, order_err = 0;
  logic b_hs_flag = 1'b0;
  logic prev_aw_pend = 1'b0, prev_w_pend = 1'b0;
  aw_t prev_aw;
  w_t  prev_w;

  // Monitor: DUT outputs only move on posedge and bench inputs move at
  // posedge+1, so negedge values equal the values at the next posedge.
  always @(negedge axi_aclk) begin
    if (axi_reset) begin
      b_hs_flag = 1'b0; b_owed = 0; aw_out = 0;
      prev_aw_pend = 1'b0; prev_w_pend = 1'b0;
    end else begin
      if (prev_aw_pend && !(axi_awvalid && axi_awaddr == prev_aw.addr && axi_awlen == prev_aw.len))
        stab_err++;
      if (prev_w_pend && !(axi_wvalid && axi_wdata == prev_w.data && axi_wlast == prev_w.last))
        stab_err++;
      if (axi_awvalid && (aw_out != 0 || b_owed != 0)) order_err++;
      if (axi_wvalid && aw_out == 0) order_err++;
      prev_aw_pend = axi_awvalid && !axi_awready;
      prev_aw      = '{axi_awaddr, axi_awlen};
      prev_w_pend  = axi_wvalid && !axi_wready;
      prev_w       = '{axi_wdata, axi_wlast};
      if (axi_awvalid && axi_awready) begin
        obs_aw.push_back('{axi_awaddr, axi_awlen});
        aw_out++;
      end
      if (axi_wvalid && axi_wready) begin
        obs_w.push_back('{axi_wdata, axi_wlast});
        if (axi_wlast) begin aw_out--; b_owed++; end
      end
      b_hs_flag = axi_bvalid && axi_bready;
      if (b_hs_flag) b_owed--;
      if (frame_done) fd_cnt++;
    end
  end

  // AXI slave responder.
  initial begin
    forever begin
      @(posedge axi_aclk);
      #1;
      axi_awready = (stall != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      axi_wready  = (stall != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (axi_reset) axi_bvalid = 1'b0;
      else if (b_hs_flag) axi_bvalid = 1'b0;
      else if (!axi_bvalid && b_owed > 0 && (stall == 0 || $urandom_range(0, 1) == 1)) begin
        axi_bvalid = 1'b1;
        axi_bresp  = (bcount == err_at) ? 2'b10 : 2'b00;
        bcount++;
      end
    end
  end

  // Drives one frame, pushing expected AW/W to the scoreboard, and waits for frame_done.
  task automatic send_frame(input int n, input logic [31:0] base, output bit ok);
    int start_fd, budget;
    start_fd = fd_cnt;
    ok = 1'b1;
    for (int b = 0; b * BURST_LEN < n; b++) begin
      int sz;
      sz = n - b * BURST_LEN;
      if (sz > BURST_LEN) sz = BURST_LEN;
      exp_aw.push_back('{base + 32'(b * BURST_LEN * (DSIZE / 8)), 8'(sz - 1)});
    end
    cfg_base_addr = base;
    for (int i = 0; i < n; i++) begin
      int st, sz;
      logic [31:0] d;
      st = (i / BURST_LEN) * BURST_LEN;
      sz = n - st;
      if (sz > BURST_LEN) sz = BURST_LEN;
      d = $urandom;
      exp_w.push_back('{d, (i - st) == sz - 1});
      s_tdata = d; s_tvalid = 1'b1; s_tlast = (i == n - 1);
      budget = 0;
      @(negedge axi_aclk);
      while (!s_tready && budget < 500) begin @(negedge axi_aclk); budget++; end
      if (!s_tready) begin ok = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; return; end
      @(posedge axi_aclk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    budget = 0;
    while (fd_cnt == start_fd && budget < 2000) begin @(negedge axi_aclk); budget++; end
    ok = (fd_cnt != start_fd);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge axi_aclk);
    total++;
    if ({s_tready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready, frame_done, wr_err} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000000",
        {s_tready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready, frame_done, wr_err});
    end
    total++;
    if (axi_awsize !== 3'd2) begin bad++; $display("FAIL awsize: got %0d want 2", axi_awsize); end
    total++;
    if (axi_awburst !== 2'b01) begin bad++; $display("FAIL awburst: got %b want 01", axi_awburst); end
    total++;
    if (axi_wstrb !== 4'hf) begin bad++; $display("FAIL wstrb: got %h want f", axi_wstrb); end
    total++;
    if ({axi_awid, axi_awlock, axi_awcache, axi_awprot, axi_awqos} !== 16'd0) begin
      bad++; $display("FAIL tied_fields: got %h want 0", {axi_awid, axi_awlock, axi_awcache, axi_awprot, axi_awqos});
    end
    @(posedge axi_aclk); #1;
    axi_reset = 1'b0;
    repeat (2) @(posedge axi_aclk); #1;
  endtask

  // 40-beat, 1-beat and 32-beat frames with the slave always ready.
  task automatic test_frames();
    int          fr_n[3]    = '{40, 1, 32};
    logic [31:0] fr_base[3] = '{32'h1000, 32'h2000, 32'h3000};
    for (int f = 0; f < 3; f++) begin
      bit ok;
      int fd0;
      fd0 = fd_cnt;
      send_frame(fr_n[f], fr_base[f], ok);
      repeat (6) @(negedge axi_aclk);
      total++;
      if (!ok) begin bad++; $display("FAIL frame%0d_timeout: got no frame_done want frame_done", f); end
      total++;
      if (fd_cnt - fd0 != 1) begin bad++; $display("FAIL frame%0d_done_count: got %0d want 1", f, fd_cnt - fd0); end
      total++;
      if (obs_aw.size() != exp_aw.size()) begin
        bad++; $display("FAIL frame%0d_aw_count: got %0d want %0d", f, obs_aw.size(), exp_aw.size());
      end
      while (exp_aw.size() > 0 && obs_aw.size() > 0) begin
        aw_t e, o;
        e = exp_aw.pop_front(); o = obs_aw.pop_front();
        total++;
        if (o !== e) begin bad++; $display("FAIL frame%0d_aw: got %h/%0d want %h/%0d", f, o.addr, o.len, e.addr, e.len); end
      end
      total++;
      if (obs_w.size() != exp_w.size()) begin
        bad++; $display("FAIL frame%0d_w_count: got %0d want %0d", f, obs_w.size(), exp_w.size());
      end
      while (exp_w.size() > 0 && obs_w.size() > 0) begin
        w_t e, o;
        e = exp_w.pop_front(); o = obs_w.pop_front();
        total++;
        if (o !== e) begin bad++; $display("FAIL frame%0d_w: got %h/%b want %h/%b", f, o.data, o.last, e.data, e.last); end
      end
      exp_aw.delete(); obs_aw.delete(); exp_w.delete(); obs_w.delete();
    end
  endtask

  task automatic test_stalls();
    bit ok;
    stall = 1;
    stab_err = 0; order_err = 0;
    send_frame(40, 32'h1000, ok);
    repeat (6) @(negedge axi_aclk);
    stall = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL stall_timeout: got no frame_done want frame_done"); end
    total++;
    if (stab_err != 0) begin bad++; $display("FAIL stall_stability: got %0d want 0", stab_err); end
    total++;
    if (order_err != 0) begin bad++; $display("FAIL stall_ordering: got %0d want 0", order_err); end
    total++;
    if (obs_aw.size() != exp_aw.size()) begin
      bad++; $display("FAIL stall_aw_count: got %0d want %0d", obs_aw.size(), exp_aw.size());
    end
    while (exp_aw.size() > 0 && obs_aw.size() > 0) begin
      aw_t e, o;
      e = exp_aw.pop_front(); o = obs_aw.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL stall_aw: got %h/%0d want %h/%0d", o.addr, o.len, e.addr, e.len); end
    end
    total++;
    if (obs_w.size() != exp_w.size()) begin
      bad++; $display("FAIL stall_w_count: got %0d want %0d", obs_w.size(), exp_w.size());
    end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      w_t e, o;
      e = exp_w.pop_front(); o = obs_w.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL stall_w: got %h/%b want %h/%b", o.data, o.last, e.data, e.last); end
    end
    exp_aw.delete(); obs_aw.delete(); exp_w.delete(); obs_w.delete();
  endtask

  task automatic test_bresp_err();
    bit ok;
    total++;
    if (wr_err !== 1'b0) begin bad++; $display("FAIL err_before: got %b want 0", wr_err); end
    err_at = bcount + 1;
    send_frame(40, 32'h6000, ok);
    err_at = -1;
    repeat (10) @(negedge axi_aclk);
    total++;
    if (!ok) begin bad++; $display("FAIL err_timeout: got no frame_done want frame_done"); end
    total++;
    if (wr_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", wr_err); end
    total++;
    if (obs_aw.size() != exp_aw.size()) begin
      bad++; $display("FAIL err_aw_count: got %0d want %0d", obs_aw.size(), exp_aw.size());
    end
    while (exp_aw.size() > 0 && obs_aw.size() > 0) begin
      aw_t e, o;
      e = exp_aw.pop_front(); o = obs_aw.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL err_aw: got %h/%0d want %h/%0d", o.addr, o.len, e.addr, e.len); end
    end
    total++;
    if (obs_w.size() != exp_w.size()) begin
      bad++; $display("FAIL err_w_count: got %0d want %0d", obs_w.size(), exp_w.size());
    end
    exp_aw.delete(); obs_aw.delete(); exp_w.delete(); obs_w.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int budget;
    stall = 1;
    cfg_base_addr = 32'h4000;
    s_tdata = $urandom; s_tvalid = 1'b1; s_tlast = 1'b0;
    budget = 0;
    @(negedge axi_aclk);
    while (!axi_wvalid && budget < 500) begin @(negedge axi_aclk); budget++; end
    total++;
    if (!axi_wvalid) begin bad++; $display("FAIL mid_reach_data: got wvalid 0 want 1"); end
    #2;
    axi_reset = 1'b1;
    #1;
    total++;
    if ({s_tready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready, frame_done, wr_err} !== 7'b0) begin
      bad++; $display("FAIL mid_reset_ctrl: got %b want 0000000",
        {s_tready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready, frame_done, wr_err});
    end
    s_tvalid = 1'b0;
    stall = 0;
    repeat (2) @(negedge axi_aclk);
    @(posedge axi_aclk); #1;
    exp_aw.delete(); obs_aw.delete(); exp_w.delete(); obs_w.delete();
    axi_reset = 1'b0;
    repeat (2) @(posedge axi_aclk); #1;
    send_frame(20, 32'h5000, ok);
    repeat (6) @(negedge axi_aclk);
    total++;
    if (!ok) begin bad++; $display("FAIL post_reset_timeout: got no frame_done want frame_done"); end
    total++;
    if (wr_err !== 1'b0) begin bad++; $display("FAIL post_reset_err: got %b want 0", wr_err); end
    total++;
    if (obs_aw.size() != exp_aw.size()) begin
      bad++; $display("FAIL post_reset_aw_count: got %0d want %0d", obs_aw.size(), exp_aw.size());
    end
    while (exp_aw.size() > 0 && obs_aw.size() > 0) begin
      aw_t e, o;
      e = exp_aw.pop_front(); o = obs_aw.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL post_reset_aw: got %h/%0d want %h/%0d", o.addr, o.len, e.addr, e.len); end
    end
    total++;
    if (obs_w.size() != exp_w.size()) begin
      bad++; $display("FAIL post_reset_w_count: got %0d want %0d", obs_w.size(), exp_w.size());
    end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      w_t e, o;
      e = exp_w.pop_front(); o = obs_w.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL post_reset_w: got %h/%b want %h/%b", o.data, o.last, e.data, e.last); end
    end
    exp_aw.delete(); obs_aw.delete(); exp_w.delete(); obs_w.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frames();
    test_stalls();
    test_bresp_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
